// File: rtl/multi_port_bus_arbiter.sv
// ---------------------------------------------------------------------------
// multi_port_bus_arbiter
// Central bus arbiter. Grants the shared bus to one requesting port at a time
// for that port's requested number of transfer cycles. Priority write-back
// (PWB) requests beat plain writes. There is one dead arbitration cycle
// between consecutive owners.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   : round-robin among candidates, starting after the last winner
//   undefined : fixed priority, lowest candidate index wins
//
// Parameters
//   NUM_PORTS  number of requesting devices (2..16)
//   CYC_W      width of each per-port transfer-length field
//   OWN_W      owner index width, max(1, clog2(NUM_PORTS))
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   req         per-port level request
//   req_type    per-port class: 0 = write, 1 = priority write-back
//   tran_cycle  per-port transfer length, port i at [i*CYC_W +: CYC_W]
//   grant       one-hot registered bus grant
//   done        one-cycle pulse in the last granted cycle of a port
//   bus_active  high while any grant is high
//   owner       index of current grantee, holds last value when idle
//   owner_type  req_type of current grantee captured at grant
// ---------------------------------------------------------------------------
module multi_port_bus_arbiter #(
   parameter int unsigned NUM_PORTS = 4,
   parameter int unsigned CYC_W     = 6,
   parameter int unsigned OWN_W     = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_PORTS-1:0]       req,
   input  logic [NUM_PORTS-1:0]       req_type,
   input  logic [NUM_PORTS*CYC_W-1:0] tran_cycle,
   output logic [NUM_PORTS-1:0]       grant,
   output logic [NUM_PORTS-1:0]       done,
   output logic                       bus_active,
   output logic [OWN_W-1:0]           owner,
   output logic                       owner_type
);

   typedef enum logic {S_IDLE = 1'b0, S_XFER = 1'b1} state_e;

   state_e                 state_q, state_d;
   logic [NUM_PORTS-1:0]   grant_q, grant_d;
   logic [NUM_PORTS-1:0]   done_q, done_d;
   logic                   bus_active_q, bus_active_d;
   logic [OWN_W-1:0]       owner_q, owner_d;
   logic                   owner_type_q, owner_type_d;
   logic [CYC_W-1:0]       cnt_q, cnt_d;

   logic [NUM_PORTS-1:0]   pwb;
   logic [NUM_PORTS-1:0]   cand;
   logic                   win_found;
   logic [OWN_W-1:0]       win_idx;
   logic [NUM_PORTS-1:0]   win_oh;
   logic                   win_type;
   logic [CYC_W-1:0]       win_len;
   logic [CYC_W-1:0]       win_cnt;

`ifdef ARB_ROUND_ROBIN_EN
   logic [OWN_W-1:0]       rr_q, rr_d;
`endif

   // Winner selection: PWB candidates mask out writes whenever any exist.
   always_comb begin
      pwb       = req & req_type;
      cand      = (|pwb) ? pwb : req;
      win_found = 1'b0;
      win_idx   = '0;
      win_oh    = '0;
      win_type  = 1'b0;
      win_len   = '0;
`ifdef ARB_ROUND_ROBIN_EN
      // Indices above the pointer first; the plain pass below supplies the wrap.
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
         if (!win_found && cand[i] && (OWN_W'(i) > rr_q)) begin
            win_found = 1'b1;
            win_idx   = OWN_W'(i);
            win_oh[i] = 1'b1;
            win_type  = req_type[i];
            win_len   = tran_cycle[i*CYC_W +: CYC_W];
         end
      end
`endif
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
         if (!win_found && cand[i]) begin
            win_found = 1'b1;
            win_idx   = OWN_W'(i);
            win_oh[i] = 1'b1;
            win_type  = req_type[i];
            win_len   = tran_cycle[i*CYC_W +: CYC_W];
         end
      end
      // A zero length is treated as a single-cycle transfer.
      win_cnt = (win_len == '0) ? '0 : win_len - CYC_W'(1);
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      done_d       = '0;
      owner_d      = owner_q;
      owner_type_d = owner_type_q;
      cnt_d        = cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
      rr_d         = rr_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (|req) begin
               state_d      = S_XFER;
               grant_d      = win_oh;
               owner_d      = win_idx;
               owner_type_d = win_type;
               cnt_d        = win_cnt;
               // Single-cycle transfer: done coincides with the first grant cycle.
               if (win_cnt == '0) begin
                  done_d = win_oh;
               end
`ifdef ARB_ROUND_ROBIN_EN
               rr_d         = win_idx;
`endif
            end
         end
         S_XFER: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CYC_W'(1);
               // Raise done for the cycle in which cnt reaches zero.
               if (cnt_q == CYC_W'(1)) begin
                  done_d = grant_q;
               end
            end else begin
               grant_d = '0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
      endcase
      bus_active_d = |grant_d;
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         grant_q      <= '0;
         done_q       <= '0;
         bus_active_q <= 1'b0;
         owner_q      <= '0;
         owner_type_q <= 1'b0;
         cnt_q        <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         rr_q         <= OWN_W'(NUM_PORTS - 1);
`endif
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         done_q       <= done_d;
         bus_active_q <= bus_active_d;
         owner_q      <= owner_d;
         owner_type_q <= owner_type_d;
         cnt_q        <= cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
         rr_q         <= rr_d;
`endif
      end
   end

   assign grant      = grant_q;
   assign done       = done_q;
   assign bus_active = bus_active_q;
   assign owner      = owner_q;
   assign owner_type = owner_type_q;

endmodule

// File: tb/tb_multi_port_bus_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for multi_port_bus_arbiter. A transfer-level reference model
// predicts each grant (port, class, length, start cycle) and queues it; an
// independent monitor pops entries as grants begin and checks every output
// cycle by cycle. Honours ARB_ROUND_ROBIN_EN like the design.
// ---------------------------------------------------------------------------
module tb_multi_port_bus_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned CW = 6;
   localparam int unsigned OW = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req;
   logic [N-1:0]      req_type;
   logic [N*CW-1:0]   tran_cycle;
   logic [N-1:0]      grant;
   logic [N-1:0]      done;
   logic              bus_active;
   logic [OW-1:0]     owner;
   logic              owner_type;

   multi_port_bus_arbiter #(.NUM_PORTS(N), .CYC_W(CW), .OWN_W(OW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_type   (req_type),
      .tran_cycle (tran_cycle),
      .grant      (grant),
      .done       (done),
      .bus_active (bus_active),
      .owner      (owner),
      .owner_type (owner_type)
   );

   always #5 clk = ~clk;

   typedef struct {
      int port;
      bit typ;
      int len;
      int start;
   } xfer_t;

   xfer_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Model state
   int  next_arb = 0;
   int  rr       = N - 1;
   bit  kill     = 1'b0;
   logic [N-1:0] m_cand;
   int  m_win;
   int  m_len;
   int  m_idx;

   // Monitor state
   bit    cur_act   = 1'b0;
   xfer_t cur;
   int    cur_rem   = 0;
   int    last_own  = 0;
   bit    last_typ  = 1'b0;
   logic [N-1:0] exp_g;
   logic [N-1:0] exp_d;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   // Reference model: arbitrates whenever the bus is free, using the
   // class/round-robin rules directly on the sampled request vector.
   always @(posedge clk) begin
      if (rst) begin
         next_arb = cyc + 1;
         rr       = N - 1;
         kill     = 1'b1;
      end else if (cyc >= next_arb && req != '0) begin
         m_cand = ((req & req_type) != '0) ? (req & req_type) : req;
         m_win  = -1;
`ifdef ARB_ROUND_ROBIN_EN
         for (int k = 1; k <= int'(N); k++) begin
            m_idx = (rr + k) % int'(N);
            if (m_win < 0 && m_cand[m_idx]) m_win = m_idx;
         end
`else
         for (int i = 0; i < int'(N); i++) begin
            if (m_win < 0 && m_cand[i]) m_win = i;
         end
`endif
         m_len = int'(CW'(tran_cycle >> (m_win * int'(CW))));
         if (m_len == 0) m_len = 1;
         exp_q.push_back('{m_win, req_type[m_win], m_len, cyc + 1});
         rr       = m_win;
         next_arb = cyc + 1 + m_len;
      end
      cyc = cyc + 1;
   end

   // Monitor: compares every output each cycle against the expected transfer.
   always @(negedge clk) begin
      if (cyc >= 1) begin
         if (kill) begin
            kill     = 1'b0;
            cur_act  = 1'b0;
            last_own = 0;
            last_typ = 1'b0;
         end
         if (exp_q.size() > 0 && exp_q[0].start == cyc) begin
            cur      = exp_q.pop_front();
            cur_act  = 1'b1;
            cur_rem  = cur.len;
            last_own = cur.port;
            last_typ = cur.typ;
         end
         exp_g = '0;
         exp_d = '0;
         if (cur_act) begin
            exp_g[cur.port] = 1'b1;
            if (cur_rem == 1) exp_d = exp_g;
         end
         chk("grant", 32'(grant), 32'(exp_g));
         chk("done", 32'(done), 32'(exp_d));
         chk("bus_active", 32'(bus_active), 32'(cur_act));
         chk("owner", 32'(owner), 32'(last_own));
         chk("owner_type", 32'(owner_type), 32'(last_typ));
         if (cur_act) begin
            cur_rem--;
            if (cur_rem == 0) cur_act = 1'b0;
         end
      end
   end

   task automatic set_len(input int port, input int len);
      tran_cycle[port*int'(CW) +: CW] = CW'(len);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst        = 1'b1;
      req        = '0;
      req_type   = '0;
      tran_cycle = '0;
      step(2);
      rst = 1'b0;
      step(2);

      // Single write on port 0, length 3
      set_len(0, 3);
      req = 4'b0001;
      step(1);
      req = '0;
      step(6);

      // All ports writing, length 2 each
      for (int i = 0; i < int'(N); i++) set_len(i, 2);
      req = 4'b1111;
      step(16);
      req = '0;
      step(4);

      // PWB on port 1 beats write on port 0
      req_type = 4'b0010;
      req      = 4'b0011;
      step(2);
      req      = 4'b0001;
      step(3);
      req      = '0;
      req_type = '0;
      step(4);

      // Zero length on port 2
      set_len(2, 0);
      req = 4'b0100;
      step(1);
      req = '0;
      step(4);

      // Port 1 length 5, owner drops request early
      set_len(1, 5);
      req = 4'b0010;
      step(2);
      req = '0;
      step(8);

      // Reset in the 3rd cycle of a 6-cycle transfer
      set_len(0, 6);
      req = 4'b0001;
      step(1);
      req = '0;
      step(2);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      set_len(0, 2);
      req = 4'b0001;
      step(1);
      req = '0;
      step(5);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(2) == 0) begin
            req      = N'($urandom);
            req_type = N'($urandom);
         end
         if ($urandom_range(3) == 0) begin
            for (int i = 0; i < int'(N); i++) begin
               if ($urandom_range(49) == 0) set_len(i, int'($urandom_range(63)));
               else                         set_len(i, int'($urandom_range(7)));
            end
         end
         rst = ($urandom_range(199) == 0);
         step(1);
      end
      rst = 1'b0;
      req = '0;
      step(80);

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      chk("idle_at_end", 32'(cur_act), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
